spi_rx_fifo: RTL

Receive-side byte buffer between the SPI master's MISO shift register and the byte display / LED readout. Captures each completed MISO byte on the master's byte-done strobe, holds up to DEPTH bytes, and releases one byte per debounced read pulse from the user button. Drives FIFO_EMPTY / FIFO_FULL LEDs and a sticky overflow flag.

---
 rtl/spi_rx_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: SPI receive byte FIFO with edge-detected write strobe, 1-cycle read latency and a sticky overflow flag.
// Define FIFO_OVERWRITE_EN to keep the newest DEPTH bytes when a write arrives while full.
module spi_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_stb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              stb_q, rd_valid_q, rd_valid_d, ovf_q, ovf_d;
  logic              push, pop, lost, wr_en, drop_old;

  assign push  = wr_stb & ~stb_q;
  assign empty = count_q == '0;
  assign full  = count_q == (ADDR_W+1)'(DEPTH);
  assign pop   = rd_req & ~empty;
  // a pop in the same cycle frees the slot, so only an unpaired push while full loses data
  assign lost  = push & full & ~pop;
`ifdef FIFO_OVERWRITE_EN
  assign wr_en    = push;
  assign drop_old = lost;
`else
  assign wr_en    = push & ~lost;
  assign drop_old = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = (pop | drop_old) ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = (wr_en & ~pop & ~drop_old) ? count_q + (ADDR_W+1)'(1) :
                 (pop & ~wr_en)             ? count_q - (ADDR_W+1)'(1) : count_q;
    rd_data_d  = pop ? mem[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop;
    ovf_d      = lost | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      stb_q      <= wr_stb;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;
endmodule
